// File: rtl/kbd_event_ctrl.sv
// PS/2 scan-code decoder: strips E0/F0 prefixes, tracks held key and modifiers,
// and buffers decoded events in a small FIFO for a valid/ack consumer.
module kbd_event_ctrl #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_50,
  input  logic                          clrn,
  input  logic                          ready,
  input  logic [7:0]                    data,
  output logic                          nextdata_n,
  input  logic                          ev_ack,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic                          ev_rep,
  output logic                          shift_on,
  output logic                          ctrl_on,
  output logic                          caps_on,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  // Handshake: a byte is taken when ready=1 and nextdata_n=1; nextdata_n then
  // pulses low for one cycle. The consumer pops the head when ev_valid=1 and ev_ack=1.
  state_t      state, state_nx;
  logic        acc;
  logic        emit, emit_ext, emit_brk;
  logic        pend_v, pend_ext, pend_brk;
  logic [7:0]  pend_code;
  logic [8:0]  pend_key, held_key;
  logic        held_v, is_rep;
  logic        lshift, rshift, lctrl, rctrl;
  logic [10:0] mem [FIFO_DEPTH];
  logic [10:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic        full, do_push, do_pop;

  assign acc       = ready & nextdata_n;
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (acc) begin
      case (state)
        IDLE: begin
          if (data == 8'hE0)      state_nx = EXT;
          else if (data == 8'hF0) state_nx = BRK;
          else                    emit = 1'b1;
        end
        EXT: begin
          if (data == 8'hF0)      state_nx = EXT_BRK;
          else if (data == 8'hE0) state_nx = EXT;
          else begin
            emit = 1'b1; emit_ext = 1'b1; state_nx = IDLE;
          end
        end
        BRK: begin
          state_nx = IDLE;
          if (data != 8'hE0 && data != 8'hF0) begin
            emit = 1'b1; emit_brk = 1'b1;
          end
        end
        EXT_BRK: begin
          state_nx = IDLE;
          if (data != 8'hE0 && data != 8'hF0) begin
            emit = 1'b1; emit_brk = 1'b1; emit_ext = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50 or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      nextdata_n <= 1'b1;
      pend_v     <= 1'b0;
      pend_ext   <= 1'b0;
      pend_brk   <= 1'b0;
      pend_code  <= 8'h00;
    end else begin
      state      <= state_nx;
      nextdata_n <= ~acc;
      pend_v     <= emit;
      if (emit) begin
        pend_ext  <= emit_ext;
        pend_brk  <= emit_brk;
        pend_code <= data;
      end
    end
  end

  // Repeat is judged against the single most recent make that has not been broken.
  assign pend_key = {pend_ext, pend_code};
  assign is_rep   = pend_v & ~pend_brk & held_v & (held_key == pend_key);

  always_ff @(posedge clk_50 or negedge clrn) begin
    if (!clrn) begin
      held_v   <= 1'b0;
      held_key <= 9'h000;
      lshift   <= 1'b0;
      rshift   <= 1'b0;
      lctrl    <= 1'b0;
      rctrl    <= 1'b0;
      caps_on  <= 1'b0;
    end else if (pend_v) begin
      if (!pend_brk) begin
        if (!is_rep) begin
          held_key <= pend_key;
          held_v   <= 1'b1;
        end
      end else if (held_v && held_key == pend_key) begin
        held_v <= 1'b0;
      end
      if (pend_key == 9'h012) lshift <= ~pend_brk;
      if (pend_key == 9'h059) rshift <= ~pend_brk;
      if (pend_key == 9'h014) lctrl  <= ~pend_brk;
      if (pend_key == 9'h114) rctrl  <= ~pend_brk;
      if (pend_key == 9'h058 && !pend_brk && !is_rep) caps_on <= ~caps_on;
    end
  end

  assign shift_on = lshift | rshift;
  assign ctrl_on  = lctrl | rctrl;

  // A pop on the same edge frees the slot, so a full FIFO still takes the push.
  assign full     = (ev_count == DEPTH_C);
  assign ev_valid = (ev_count != '0);
  assign do_pop   = ev_valid & ev_ack;
  assign do_push  = pend_v & (~full | do_pop);

  always_ff @(posedge clk_50) begin
    if (do_push) mem[wr_ptr] <= {is_rep, pend_brk, pend_ext, pend_code};
  end

  always_ff @(posedge clk_50 or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   ev_count <= ev_count + 1'b1;
        2'b01:   ev_count <= ev_count - 1'b1;
        default: ev_count <= ev_count;
      endcase
      if (pend_v && full && !do_pop) overflow <= 1'b1;
    end
  end

  assign head     = mem[rd_ptr];
  assign ev_code  = ev_valid ? head[7:0] : 8'h00;
  assign ev_ext   = ev_valid & head[8];
  assign ev_break = ev_valid & head[9];
  assign ev_rep   = ev_valid & head[10];

endmodule
